// File: rtl/tinygpu_pkg.sv
// tinygpu_pkg: command byte layout shared by cmd_ingress and command_decoder.
package tinygpu_pkg;
  localparam int CMD_W      = 8;
  localparam int CMD_OP_MSB = 7;
  localparam int CMD_OP_LSB = 6;
  localparam int CMD_X_MSB  = 5;
  localparam int CMD_X_LSB  = 3;
  localparam int CMD_Y_MSB  = 2;
  localparam int CMD_Y_LSB  = 0;
  typedef logic [CMD_W-1:0] cmd_byte_t;
  function automatic logic odd_parity_ok(input cmd_byte_t d, input logic p);
    return ^{d, p};
  endfunction
endpackage

// File: rtl/strobe_sync_edge.sv
// strobe_sync_edge: synchronizes an async strobe and emits a one-cycle registered rising-edge pulse.
// The chain and edge flop reset to 1 so a strobe held high through reset is not seen as an edge.
module strobe_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic pulse
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic prev_q, prev_d, pulse_q, pulse_d;
  // shift the strobe through the synchronizer and detect the rising edge on its output
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], async_in};
    prev_d  = sync_q[SYNC_STAGES-1];
    pulse_d = sync_q[SYNC_STAGES-1] & ~prev_q;
  end
  // synchronizer and edge flops reset high; the pulse register resets low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '1;
      prev_q  <= 1'b1;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
    end
  end
  assign pulse = pulse_q;
endmodule

// File: rtl/cmd_ingress.sv
// cmd_ingress: captures host command bytes on an async strobe into a FWFT FIFO with valid/ready output.
// Optional odd-parity check on each byte when CMD_INGRESS_PARITY_EN is defined.
module cmd_ingress
  import tinygpu_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               pin_data,
  input  logic                     pin_strobe,
  input  logic                     pin_parity,
  input  logic                     clear,
  output logic [7:0]               cmd_data,
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  output logic                     parity_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic push_req, parity_ok, full, pop, push;
  cmd_byte_t mem_q [DEPTH];
  cmd_byte_t mem_d [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic ovf_q, ovf_d, perr_q, perr_d;

  strobe_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (pin_strobe),
    .pulse    (push_req)
  );

`ifdef CMD_INGRESS_PARITY_EN
  assign parity_ok = odd_parity_ok(pin_data, pin_parity);
`else
  logic unused_parity;
  assign unused_parity = pin_parity;
  assign parity_ok     = 1'b1;
`endif

  assign full      = level_q == LW'(DEPTH);
  assign cmd_valid = level_q != '0;
  assign cmd_data  = cmd_valid ? mem_q[rd_ptr_q] : '0;

  // handshake, pointer/level update and sticky flags; clear overrides any push or pop
  always_comb begin
    pop      = cmd_valid & cmd_ready;
    push     = push_req & parity_ok & (~full | pop);
    rd_ptr_d = clear ? '0 : rd_ptr_q + AW'(pop);
    wr_ptr_d = clear ? '0 : wr_ptr_q + AW'(push);
    level_d  = clear ? '0 : level_q + LW'(push) - LW'(pop);
    ovf_d    = ~clear & (ovf_q | (push_req & parity_ok & full & ~pop));
    perr_d   = ~clear & (perr_q | (push_req & ~parity_ok));
    mem_d    = mem_q;
    if (push & ~clear) mem_d[wr_ptr_q] = pin_data;
  end

  // storage is not reset; entries are only observable once written
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // control state with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      perr_q   <= perr_d;
    end
  end

  assign fifo_level = level_q;
  assign overflow   = ovf_q;
  assign parity_err = perr_q;
endmodule

// File: tb/tb_cmd_ingress.sv
// tb_cmd_ingress: directed and randomized checks of cmd_ingress against a queue-based reference model.
module tb_cmd_ingress;
  localparam int DEPTH = 4;
  localparam int LAT   = 3;
  logic clk = 0, rst_n = 0, pin_strobe = 0, pin_parity = 0, clear = 0, cmd_ready = 0;
  logic [7:0] pin_data = 0, cmd_data;
  logic cmd_valid, overflow, parity_err;
  logic [2:0] fifo_level;
  int checks = 0, errors = 0;
  logic [7:0] q[$];
  bit m_ovf, m_perr, prev_s = 1, sched_v = 0, rnd = 0;
  longint ecount = 0, sched_e = 0;
  logic [7:0] sched_d;
  logic sched_p;

  always #5 clk = ~clk;

  cmd_ingress dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pin_data   (pin_data),
    .pin_strobe (pin_strobe),
    .pin_parity (pin_parity),
    .clear      (clear),
    .cmd_data   (cmd_data),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .parity_err (parity_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic good_par(input logic [7:0] d);
    return ~^d;
  endfunction

  function automatic void model_reset();
    q.delete();
    m_ovf   = 0;
    m_perr  = 0;
    prev_s  = 1;
    sched_v = 0;
  endfunction

  // one clock: model a strobe seen high on this edge as a push LAT edges later
  task automatic step();
    bit fire, pop, pok;
    if (rnd) begin
      cmd_ready = 1'($urandom_range(0, 1));
      clear     = ($urandom_range(0, 24) == 0);
    end
    @(posedge clk);
    fire = sched_v && sched_e == ecount;
    pop  = cmd_ready && q.size() > 0;
`ifdef CMD_INGRESS_PARITY_EN
    pok = (^{sched_d, sched_p}) == 1'b1;
`else
    pok = 1;
`endif
    if (fire) sched_v = 0;
    if (clear) begin
      q.delete();
      m_ovf  = 0;
      m_perr = 0;
    end else begin
      if (pop) void'(q.pop_front());
      if (fire && !pok) m_perr = 1;
      else if (fire) begin
        if (q.size() < DEPTH) q.push_back(sched_d);
        else m_ovf = 1;
      end
    end
    if (pin_strobe && !prev_s) begin
      sched_v = 1;
      sched_e = ecount + LAT;
      sched_d = pin_data;
      sched_p = pin_parity;
    end
    prev_s = pin_strobe;
    ecount++;
    @(negedge clk);
    check("valid", 32'(cmd_valid), 32'(q.size() > 0));
    if (q.size() > 0) check("data", 32'(cmd_data), 32'(q[0]));
    check("level", 32'(fifo_level), 32'(q.size()));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("parity_err", 32'(parity_err), 32'(m_perr));
  endtask

  task automatic send(input logic [7:0] d, input logic p);
    pin_data   = d;
    pin_parity = p;
    pin_strobe = 1;
    repeat (3) step();
    pin_strobe = 0;
    repeat (3) step();
  endtask

  task automatic drain_expect(input logic [7:0] e);
    check("drain_data", 32'(cmd_data), 32'(e));
    cmd_ready = 1;
    step();
    cmd_ready = 0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(cmd_valid), 0);
    check("rst_data", 32'(cmd_data), 0);
    check("rst_level", 32'(fifo_level), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_parity_err", 32'(parity_err), 0);
    rst_n = 1;
    model_reset();
    repeat (2) step();

    pin_data   = 8'hA5;
    pin_parity = good_par(8'hA5);
    pin_strobe = 1;
    repeat (3) step();
    check("lat_early_valid", 32'(cmd_valid), 0);
    step();
    check("lat_valid", 32'(cmd_valid), 1);
    check("lat_data", 32'(cmd_data), 32'h A5);
    check("lat_level", 32'(fifo_level), 1);
    pin_strobe = 0;
    repeat (2) step();
    cmd_ready = 1;
    step();
    cmd_ready = 0;
    check("pop_valid", 32'(cmd_valid), 0);
    check("pop_level", 32'(fifo_level), 0);

    send(8'h11, good_par(8'h11));
    send(8'h22, good_par(8'h22));
    send(8'h33, good_par(8'h33));
    send(8'h44, good_par(8'h44));
    check("fill_level", 32'(fifo_level), 4);
    check("fill_ovf", 32'(overflow), 0);
    send(8'h55, good_par(8'h55));
    check("full_ovf", 32'(overflow), 1);
    check("full_level", 32'(fifo_level), 4);
    drain_expect(8'h11);
    drain_expect(8'h22);
    drain_expect(8'h33);
    drain_expect(8'h44);
    check("drained_valid", 32'(cmd_valid), 0);

    send(8'h01, good_par(8'h01));
    send(8'h02, good_par(8'h02));
    send(8'h03, good_par(8'h03));
    check("pre_clr_level", 32'(fifo_level), 3);
    check("pre_clr_ovf", 32'(overflow), 1);
    clear = 1;
    step();
    clear = 0;
    check("clr_level", 32'(fifo_level), 0);
    check("clr_valid", 32'(cmd_valid), 0);
    check("clr_ovf", 32'(overflow), 0);

    send(8'h11, good_par(8'h11));
    send(8'h22, good_par(8'h22));
    send(8'h33, good_par(8'h33));
    send(8'h44, good_par(8'h44));
    pin_data   = 8'h66;
    pin_parity = good_par(8'h66);
    pin_strobe = 1;
    repeat (3) step();
    cmd_ready = 1;
    step();
    cmd_ready = 0;
    check("pp_level", 32'(fifo_level), 4);
    check("pp_ovf", 32'(overflow), 0);
    pin_strobe = 0;
    repeat (2) step();
    drain_expect(8'h22);
    drain_expect(8'h33);
    cmd_ready = 1;
    #2 rst_n = 0;
    #1;
    check("arst_valid", 32'(cmd_valid), 0);
    check("arst_data", 32'(cmd_data), 0);
    check("arst_level", 32'(fifo_level), 0);
    check("arst_ovf", 32'(overflow), 0);
    check("arst_perr", 32'(parity_err), 0);
    model_reset();
    cmd_ready = 0;
    @(negedge clk);
    rst_n = 1;
    repeat (2) step();

    pin_strobe = 1;
    #2 rst_n = 0;
    model_reset();
    @(negedge clk);
    rst_n = 1;
    repeat (6) step();
    check("hold_level", 32'(fifo_level), 0);
    check("hold_valid", 32'(cmd_valid), 0);
    pin_strobe = 0;
    repeat (3) step();

`ifdef CMD_INGRESS_PARITY_EN
    send(8'h01, 1'b0);
    check("par_ok_level", 32'(fifo_level), 1);
    check("par_ok_data", 32'(cmd_data), 1);
    send(8'h01, 1'b1);
    check("par_bad_level", 32'(fifo_level), 1);
    check("par_bad_flag", 32'(parity_err), 1);
    clear = 1;
    step();
    clear = 0;
`endif

    rnd = 1;
    repeat (150) begin
      if ($urandom_range(0, 2) != 0) send(8'($urandom), 1'($urandom_range(0, 1)));
      else repeat ($urandom_range(1, 4)) step();
    end
    rnd = 0;
    cmd_ready = 0;
    clear = 0;
    repeat (4) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cmd_ingress.md
# cmd_ingress

Host-facing command ingress stage sitting directly upstream of `command_decoder` in the 8x8 rasterizer. It samples an 8-bit command byte from the input pins on a host-driven strobe. That strobe is asynchronous to `clk`. Accepted bytes go into a small FIFO, and the block presents them to the decoder with a valid/ready handshake. Commands issued faster than the graphics processor retires them are therefore buffered instead of lost.

## Interface
- `DEPTH`, default 4: FIFO entries; must be a power of two, 2..16.
- `SYNC_STAGES`, default 2: synchronizer flops on `pin_strobe`; minimum 2.
- `clk` in 1: system clock.
- `rst_n` in 1: reset; one clock, asynchronous assert, active-low.
- `pin_data` in 8: command byte from `ui_in`, laid out as {cmd[1:0], x1[2:0], y1[2:0]}, MSB first.
- `pin_strobe` in 1: host strobe from `uio_in[0]`; asynchronous; a rising edge means "byte ready".
- `pin_parity` in 1: from `uio_in[1]`; only used with the parity build (see Configuration).
- `clear` in 1: synchronous flush.
- `cmd_data` out 8: head-of-FIFO byte.
- `cmd_valid` out 1: the head entry is valid.
- `cmd_ready` in 1: decoder accepts the head byte.
- `fifo_level` out clog2(DEPTH)+1: current occupancy.
- `overflow` out 1: sticky flag; a byte was dropped because the FIFO was full.
- `parity_err` out 1: sticky flag; a byte was dropped because of bad parity.

## Operation
- **Strobe path:** `pin_strobe` → `SYNC_STAGES` synchronizer flops → one edge-detect flop.
  - `push_req` = synced & ~prev.
  - All synchronizer and edge flops reset to 1, so a strobe held high at reset release is not a command.
- **Capture:** `pin_data` and `pin_parity` are sampled directly on the cycle `push_req` is high.
  - The host holds them stable from strobe rise for at least SYNC_STAGES+2 clk periods.
- **FIFO:** circular buffer with rd_ptr and wr_ptr of clog2(DEPTH) bits; the pointers wrap modulo DEPTH.
  - `fifo_level` is a separate counter, 0..DEPTH.
  - Head data is first-word fall-through: `cmd_data` = mem[rd_ptr].
- **pop** = `cmd_valid` & `cmd_ready`.
- **push** = `push_req` & parity_ok & (level < DEPTH | pop).
- **Push and pop in the same cycle:** both happen and the level is unchanged. This includes the full case, where the write lands in the slot being freed.
- **Drop on full:** `push_req` & parity_ok & level == DEPTH & ~pop → byte dropped, `overflow` ← 1.
- **Empty:** `cmd_valid` = 0; `cmd_data` is don't-care; `cmd_ready` is ignored.
- **`clear` has priority over everything in its cycle:**
  - pointers ← 0, level ← 0;
  - `overflow` and `parity_err` ← 0;
  - any concurrent push or pop is discarded.
- **Sticky flags:** cleared only by `clear` or reset.
- **Reset (asynchronous, mid-operation):** all of the following go to 0 immediately: pointers, level, `cmd_valid`, `overflow`, `parity_err`, `cmd_data`.
  - FIFO contents are not reset; they are unobservable until written.

## Timing
- Reset values: `cmd_valid` = 0, `cmd_data` = 8'h00, `fifo_level` = 0, `overflow` = 0, `parity_err` = 0.
- **Latency**, counting from the first clk edge that samples `pin_strobe` high:
  - `push_req` is high SYNC_STAGES cycles later;
  - `cmd_valid` rises on the next edge;
  - total SYNC_STAGES+1 cycles (3 by default) with an empty FIFO.
- **Handshake:** `cmd_valid` does not drop and `cmd_data` does not change until a pop occurs, or `clear` or reset.
- **Back-to-back pops:** the decoder may hold `cmd_ready` high continuously; one byte retires per cycle.
- **Strobe rate:** the minimum strobe period is 2×(SYNC_STAGES+1) clk cycles. Pulses shorter than 2 clk high or low are not guaranteed to be detected.

## Configuration
- **`CMD_INGRESS_PARITY_EN` defined:** parity_ok = ^{pin_data, pin_parity} == 1 (odd parity over 9 bits).
  - On a failing byte, `push_req` is dropped, `parity_err` ← 1, and `overflow` is unaffected.
  - A parity failure takes precedence over the full check.
- **Not defined:** parity_ok = 1, `pin_parity` is ignored, and `parity_err` is tied to 0.

## Structure
- **Package `tinygpu_pkg`:**
  - `CMD_W` = 8;
  - field slices `CMD_OP_MSB`/`LSB`, `CMD_X_MSB`/`LSB`, `CMD_Y_MSB`/`LSB`;
  - typedef `cmd_byte_t`.
  - `command_decoder` shares these definitions.
- **One sub-module, `strobe_sync_edge`:** parameter SYNC_STAGES, reset-to-1 chain, single-cycle rising-edge pulse output.
- FIFO storage, pointers and flags are inline in `cmd_ingress`.

## Test plan
- **Single command:** reset, then drive `pin_data` = 8'hA5 and raise the strobe.
  - `cmd_valid` rises 3 cycles after the first sampling edge, with `cmd_data` = 8'hA5 and `fifo_level` = 1.
  - `cmd_ready` = 1 for one cycle → `cmd_valid` = 0 and level 0.
- **Ordered fill:** with `cmd_ready` = 0, strobe 8'h11, 8'h22, 8'h33, 8'h44.
  - Level = 4.
  - A fifth strobe of 8'h55 → `overflow` = 1 and level stays 4.
  - Draining yields 11, 22, 33, 44 in that order.
- **Full with simultaneous push and pop:** FIFO full, `cmd_ready` = 1 on the cycle `push_req` fires with 8'h66.
  - Level stays 4 and `overflow` stays 0.
  - Drain order is 22, 33, 44, 66.
- **Clear and mid-operation reset:**
  - 3 entries plus the overflow flag set, `clear` pulsed → level 0, `cmd_valid` 0, `overflow` 0.
  - Separately, `rst_n` low mid-drain → all outputs 0 asynchronously.
- **Strobe high across reset:** hold `pin_strobe` high across reset release → no push, level 0.
- **Parity (with `CMD_INGRESS_PARITY_EN`):**
  - 8'h01 with `pin_parity` = 0 → accepted.
  - 8'h01 with `pin_parity` = 1 → dropped, `parity_err` = 1.
